// File: rtl/sobel_window_gen.sv
// Raster-scan 3x3 window generator: two line buffers plus a shifting
// 3x3 register window; strobes each complete neighbourhood one cycle later.
// Ports: clk, rst_n (async low), start, pix_valid, pix_in[DW]
//        -> win_valid, win_p1..win_p9[DW], frame_done, row_cnt[RW]
module sobel_window_gen #(
  parameter int DW    = 12,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int CW    = 7,
  parameter int RW    = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_in,
  output logic          win_valid,
  output logic [DW-1:0] win_p1,
  output logic [DW-1:0] win_p2,
  output logic [DW-1:0] win_p3,
  output logic [DW-1:0] win_p4,
  output logic [DW-1:0] win_p5,
  output logic [DW-1:0] win_p6,
  output logic [DW-1:0] win_p7,
  output logic [DW-1:0] win_p8,
  output logic [DW-1:0] win_p9,
  output logic          frame_done,
  output logic [RW-1:0] row_cnt
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_R = RW'(IMG_H - 1);
  localparam logic [CW-1:0] TWO_C  = CW'(2);
  localparam logic [RW-1:0] TWO_R  = RW'(2);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nx;
  logic [RW-1:0] w_row_nx;
  logic [AW-1:0] w_addr;
  logic          w_eol;
  logic          w_hit;
  logic          w_last;

  logic [DW-1:0] r_lb0 [IMG_W];
  logic [DW-1:0] r_lb1 [IMG_W];
  logic [DW-1:0] r_c1  [3];
  logic [DW-1:0] r_c2  [3];
  logic [DW-1:0] w_new [3];
  logic [DW-1:0] w_nxt [9];
  logic [DW-1:0] r_win [9];

  // start overrides the counters for the pixel arriving with it
  always_comb begin
    w_col    = start ? '0 : r_col;
    w_row    = start ? '0 : r_row;
    w_addr   = w_col[AW-1:0];
    w_eol    = (w_col == LAST_C);
    w_col_nx = w_eol ? '0 : w_col + CW'(1);
    w_row_nx = w_row;
    if (w_eol)
      w_row_nx = (w_row == LAST_R) ? '0 : w_row + RW'(1);
    // c>=2 gate drops windows holding columns of the previous line
    w_hit  = pix_valid && !start &&
             (w_row >= TWO_R) && (w_col >= TWO_C);
    w_last = w_hit && w_eol && (w_row == LAST_R);
    w_new[0] = r_lb1[w_addr];
    w_new[1] = r_lb0[w_addr];
    w_new[2] = pix_in;
    for (int k = 0; k < 3; k++) begin
      w_nxt[3*k]   = r_c1[k];
      w_nxt[3*k+1] = r_c2[k];
      w_nxt[3*k+2] = w_new[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (pix_valid) begin
      r_col <= w_col_nx;
      r_row <= w_row_nx;
    end else if (start) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // line buffers hold no reset: every entry is rewritten before use
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      r_lb1[w_addr] <= r_lb0[w_addr];
      r_lb0[w_addr] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        r_c1[k] <= '0;
        r_c2[k] <= '0;
      end
      for (int k = 0; k < 9; k++)
        r_win[k] <= '0;
    end else begin
      win_valid  <= w_hit;
      frame_done <= w_last;
      if (pix_valid) begin
        for (int k = 0; k < 3; k++) begin
          r_c1[k] <= r_c2[k];
          r_c2[k] <= w_new[k];
        end
      end
      if (w_hit) begin
        for (int k = 0; k < 9; k++)
          r_win[k] <= w_nxt[k];
      end
    end
  end

  assign win_p1  = r_win[0];
  assign win_p2  = r_win[1];
  assign win_p3  = r_win[2];
  assign win_p4  = r_win[3];
  assign win_p5  = r_win[4];
  assign win_p6  = r_win[5];
  assign win_p7  = r_win[6];
  assign win_p8  = r_win[7];
  assign win_p9  = r_win[8];
  assign row_cnt = r_row;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen: a 4x4 instance for framing,
// gaps, reset and start cases; a 5x3 instance for the wide-line case.
module tb_sobel_window_gen;

  logic         clk;
  logic         rst_n;
  logic         start, pix_valid;
  logic [11:0]  pix_in;
  logic         win_valid, frame_done;
  logic [11:0]  p1, p2, p3, p4, p5, p6, p7, p8, p9;
  logic [1:0]   row_cnt;
  logic [107:0] w4;

  logic         b_start, b_valid;
  logic [11:0]  b_pix;
  logic         b_wv, b_fd;
  logic [11:0]  b1, b2, b3, b4, b5, b6, b7, b8, b9;
  logic [1:0]   b_row;
  logic [107:0] w53;

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;
  int fd_idx = -1;
  logic [107:0] prev = '0;
  logic [107:0] q[$];

  sobel_window_gen #(.DW(12), .IMG_W(4), .IMG_H(4), .CW(2), .RW(2)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_valid(pix_valid),
    .pix_in(pix_in), .win_valid(win_valid),
    .win_p1(p1), .win_p2(p2), .win_p3(p3),
    .win_p4(p4), .win_p5(p5), .win_p6(p6),
    .win_p7(p7), .win_p8(p8), .win_p9(p9),
    .frame_done(frame_done), .row_cnt(row_cnt)
  );

  sobel_window_gen #(.DW(12), .IMG_W(5), .IMG_H(3), .CW(3), .RW(2)) u53 (
    .clk(clk), .rst_n(rst_n), .start(b_start), .pix_valid(b_valid),
    .pix_in(b_pix), .win_valid(b_wv),
    .win_p1(b1), .win_p2(b2), .win_p3(b3),
    .win_p4(b4), .win_p5(b5), .win_p6(b6),
    .win_p7(b7), .win_p8(b8), .win_p9(b9),
    .frame_done(b_fd), .row_cnt(b_row)
  );

  assign w4  = {p1, p2, p3, p4, p5, p6, p7, p8, p9};
  assign w53 = {b1, b2, b3, b4, b5, b6, b7, b8, b9};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [107:0] got,
                       input logic [107:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [107:0] expw(int r, int c, int off);
    logic [107:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[95:0], 12'(off + ((r - 2 + i) << 4) + (c - 2 + j))};
    return w;
  endfunction

  task automatic clr();
    q.delete();
    fd_cnt = 0;
    fd_idx = -1;
  endtask

  // one cycle on u4; inputs set after negedge, outputs read at next negedge
  task automatic feed(input logic v, input logic s, input logic [11:0] d);
    pix_valid = v;
    start     = s;
    pix_in    = d;
    @(negedge clk);
    pix_valid = 1'b0;
    start     = 1'b0;
    if (win_valid) begin
      q.push_back(w4);
      if (frame_done) begin
        fd_cnt++;
        fd_idx = q.size() - 1;
      end
    end else begin
      check("hold", w4, prev);
      check("fd_nowin", frame_done, 1'b0);
    end
    if (!v) check("idle_nowin", win_valid, 1'b0);
    prev = w4;
  endtask

  task automatic frame(input int off, input bit tog);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        feed(1'b1, 1'b0, 12'(off + (r << 4) + c));
        if (tog) feed(1'b0, 1'b0, 12'h000);
      end
  endtask

  task automatic check_frame(input int nfr);
    int k;
    check("nwin", q.size(), 4 * nfr);
    for (int i = 0; i < q.size(); i++)
      if (i < 4 * nfr) begin
        k = i % 4;
        check("win", q[i], expw(2 + k / 2, 2 + k % 2, (i / 4) * 256));
      end
    check("fd_cnt", fd_cnt, nfr);
    check("fd_last", fd_idx, q.size() - 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; pix_valid = 1'b0; pix_in = '0;
    b_start = 1'b0; b_valid = 1'b0; b_pix = '0;
    repeat (2) @(negedge clk);
    check("rst_wv", win_valid, 1'b0);
    check("rst_fd", frame_done, 1'b0);
    check("rst_win", w4, '0);
    check("rst_row", row_cnt, 2'd0);
    check("rst_b_wv", b_wv, 1'b0);
    check("rst_b_win", w53, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // continuous 4x4 frame
    clr();
    frame(0, 1'b0);
    check_frame(1);
    if (q.size() >= 4) begin
      check("s1_first", q[0], {12'h000, 12'h001, 12'h002,
                               12'h010, 12'h011, 12'h012,
                               12'h020, 12'h021, 12'h022});
      check("s1_last_p1", q[3][107:96], 12'h011);
      check("s1_last_p9", q[3][11:0], 12'h033);
    end
    check("s1_row", row_cnt, 2'd0);

    // pix_valid toggling
    clr();
    frame(0, 1'b1);
    check_frame(1);

    // two back-to-back frames, second offset by 0x100
    clr();
    frame(0, 1'b0);
    frame(256, 1'b0);
    check_frame(2);
    if (q.size() >= 5) begin
      check("s3_f2_p1", q[4][107:96], 12'h100);
      check("s3_f2_p9", q[4][11:0], 12'h122);
    end

    // async reset after pixel (2,3)
    clr();
    for (int i = 0; i < 12; i++)
      feed(1'b1, 1'b0, 12'(((i / 4) << 4) + i % 4));
    check("s4_pre_wv", win_valid, 1'b1);
    check("s4_pre_win", w4, expw(2, 3, 0));
    #2 rst_n = 1'b0;
    #1;
    check("s4_rst_wv", win_valid, 1'b0);
    check("s4_rst_win", w4, '0);
    check("s4_rst_row", row_cnt, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    prev = '0;
    clr();
    frame(0, 1'b0);
    check_frame(1);

    // start with a pixel at (3,1)
    clr();
    for (int i = 0; i < 13; i++)
      feed(1'b1, 1'b0, 12'(((i / 4) << 4) + i % 4));
    check("s5_pre_row", row_cnt, 2'd3);
    clr();
    feed(1'b1, 1'b1, 12'h000);
    check("s5_nowin", win_valid, 1'b0);
    check("s5_row0", row_cnt, 2'd0);
    for (int i = 1; i < 16; i++)
      feed(1'b1, 1'b0, 12'(((i / 4) << 4) + i % 4));
    check_frame(1);

    // 5x3 instance, continuous
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++) begin
        b_valid = 1'b1;
        b_pix   = 12'((r << 4) + c);
        @(negedge clk);
        b_valid = 1'b0;
        check("s6_wv", b_wv, (r == 2 && c >= 2));
        check("s6_fd", b_fd, (r == 2 && c == 4));
        if (b_wv) check("s6_win", w53, expw(r, c, 0));
      end
    check("s6_row", b_row, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
